// File: rtl/rf_wb_ctrl_pkg.sv
// Shared register-file controller types: widths, write-source tag, starvation counter width.
// Imported by the scoreboard, the bus interface and the write-port controller.
package rf_ctrl_pkg;
  localparam int XLEN         = 32;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;
  localparam int STARVE_CNT_W = 4;

  typedef enum logic {
    WB_SRC_PIPE = 1'b0,
    WB_SRC_LU   = 1'b1
  } wb_src_e;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       reg_data_t;
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// Bus bundle around the register-file write-port controller: writeback requests, issue/decode lookups, RF port.
// master = surrounding pipeline (drives i_*), slave = rf_wb_ctrl (drives o_*).
interface rf_wb_ctrl_if;
  import rf_ctrl_pkg::*;

  logic      i_wb_valid;
  reg_addr_t i_wb_rd_addr;
  reg_data_t i_wb_rd_data;
  logic      o_wb_ready;

  logic      i_lu_valid;
  reg_addr_t i_lu_rd_addr;
  reg_data_t i_lu_rd_data;
  logic      o_lu_ready;

  logic      i_iss_valid;
  reg_addr_t i_iss_rd_addr;
  reg_addr_t i_rs1_addr;
  reg_addr_t i_rs2_addr;
  logic      o_rs1_busy;
  logic      o_rs2_busy;
  logic      o_rd_busy;

  reg_addr_t o_rd_addr;
  reg_data_t o_rd_data;
  logic      o_rd_wren;

  modport master (
    output i_wb_valid, i_wb_rd_addr, i_wb_rd_data,
    output i_lu_valid, i_lu_rd_addr, i_lu_rd_data,
    output i_iss_valid, i_iss_rd_addr, i_rs1_addr, i_rs2_addr,
    input  o_wb_ready, o_lu_ready, o_rs1_busy, o_rs2_busy, o_rd_busy,
    input  o_rd_addr, o_rd_data, o_rd_wren
  );

  modport slave (
    input  i_wb_valid, i_wb_rd_addr, i_wb_rd_data,
    input  i_lu_valid, i_lu_rd_addr, i_lu_rd_data,
    input  i_iss_valid, i_iss_rd_addr, i_rs1_addr, i_rs2_addr,
    output o_wb_ready, o_lu_ready, o_rs1_busy, o_rs2_busy, o_rd_busy,
    output o_rd_addr, o_rd_data, o_rd_wren
  );
endinterface

// File: rtl/rf_wb_ctrl_scoreboard.sv
// Busy-bit scoreboard for in-flight long-latency destinations; x0 never busy, set beats clear on the same edge.
// Lookups are combinational; updates land on the clock edge.
module rf_scoreboard
  import rf_ctrl_pkg::*;
(
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      i_set_en,
  input  reg_addr_t i_set_addr,
  input  logic      i_clr_en,
  input  reg_addr_t i_clr_addr,
  input  reg_addr_t i_rs1_addr,
  input  reg_addr_t i_rs2_addr,
  input  reg_addr_t i_rd_addr,
  output logic      o_rs1_busy,
  output logic      o_rs2_busy,
  output logic      o_rd_busy
);
  logic [NUM_REGS-1:1] r_busy;
  logic [NUM_REGS-1:0] w_busy;

  assign w_busy = {r_busy, 1'b0};

  // Set is applied after clear so it wins when both target the same register.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_busy <= '0;
    end else begin
      if (i_clr_en && (i_clr_addr != '0)) begin
        r_busy[i_clr_addr] <= 1'b0;
      end
      if (i_set_en && (i_set_addr != '0)) begin
        r_busy[i_set_addr] <= 1'b1;
      end
    end
  end

  assign o_rs1_busy = w_busy[i_rs1_addr];
  assign o_rs2_busy = w_busy[i_rs2_addr];
  assign o_rd_busy  = w_busy[i_rd_addr];
endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write-port arbiter (pipeline vs long unit) with hazard scoreboard; one-cycle registered write.
// Readies are combinational; RF_WB_STARVE_GUARD_EN adds a starvation counter that forces the pipeline to yield.
module rf_wb_ctrl
  import rf_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
)
(
  input logic         i_clk,
  input logic         i_reset,
  rf_wb_ctrl_if.slave bus
);
  logic      w_force;
  logic      w_wb_grant;
  logic      w_lu_grant;
  logic      w_clr_en;

  reg_addr_t r_rd_addr;
  reg_data_t r_rd_data;
  logic      r_rd_wren;
  wb_src_e   r_src;

  if ((STARVE_LIMIT < 1) || (STARVE_LIMIT > 15)) begin : g_bad_limit
    $error("rf_wb_ctrl: STARVE_LIMIT must be within 1..15");
  end

`ifdef RF_WB_STARVE_GUARD_EN
  localparam logic [STARVE_CNT_W-1:0] LP_LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] r_starve_cnt;
  logic                    w_lu_xfer;

  assign w_force   = (r_starve_cnt == LP_LIMIT);
  assign w_lu_xfer = bus.i_lu_valid && bus.o_lu_ready;

  // A refused request implies force is clear, so the count never passes the limit.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_starve_cnt <= '0;
    end else if (w_lu_xfer) begin
      r_starve_cnt <= '0;
    end else if (bus.i_lu_valid && !bus.o_lu_ready) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end
`else
  assign w_force = 1'b0;
`endif

  assign w_wb_grant     = bus.i_wb_valid && !w_force;
  assign w_lu_grant     = bus.i_lu_valid && !w_wb_grant;
  assign bus.o_wb_ready = !w_force;
  assign bus.o_lu_ready = w_force || !bus.i_wb_valid;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rd_addr <= '0;
      r_rd_data <= '0;
      r_rd_wren <= 1'b0;
      r_src     <= WB_SRC_PIPE;
    end else if (w_wb_grant) begin
      r_rd_addr <= bus.i_wb_rd_addr;
      r_rd_data <= bus.i_wb_rd_data;
      r_rd_wren <= (bus.i_wb_rd_addr != '0);
      r_src     <= WB_SRC_PIPE;
    end else if (w_lu_grant) begin
      r_rd_addr <= bus.i_lu_rd_addr;
      r_rd_data <= bus.i_lu_rd_data;
      r_rd_wren <= (bus.i_lu_rd_addr != '0);
      r_src     <= WB_SRC_LU;
    end else begin
      r_rd_wren <= 1'b0;
    end
  end

  assign bus.o_rd_addr = r_rd_addr;
  assign bus.o_rd_data = r_rd_data;
  assign bus.o_rd_wren = r_rd_wren;

  // Busy bit retires on the same edge the register file stores the long-unit result.
  assign w_clr_en = r_rd_wren && (r_src == WB_SRC_LU);

  rf_scoreboard u_scoreboard (
    .i_clk      (i_clk),
    .i_reset    (i_reset),
    .i_set_en   (bus.i_iss_valid),
    .i_set_addr (bus.i_iss_rd_addr),
    .i_clr_en   (w_clr_en),
    .i_clr_addr (r_rd_addr),
    .i_rs1_addr (bus.i_rs1_addr),
    .i_rs2_addr (bus.i_rs2_addr),
    .i_rd_addr  (bus.i_iss_rd_addr),
    .o_rs1_busy (bus.o_rs1_busy),
    .o_rs2_busy (bus.o_rs2_busy),
    .o_rd_busy  (bus.o_rd_busy)
  );
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Self-checking bench for rf_wb_ctrl: per-cycle reference model, expected RF writes queued and popped after each edge.
`timescale 1ns/1ps
module tb_rf_wb_ctrl;
  import rf_ctrl_pkg::*;

  localparam int LIMIT = 4;
`ifdef RF_WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rf_wb_ctrl_if bus();

  rf_wb_ctrl #(.STARVE_LIMIT(LIMIT)) u_dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  wr_exp_t     exp_q[$];
  logic [31:0] m_busy;
  int          m_cnt;
  logic        m_prev_wren, m_prev_lu;
  logic [4:0]  m_prev_addr, m_last_addr;
  logic [31:0] m_last_data;
  logic        m_wb_g, m_lu_g;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    m_busy = '0; m_cnt = 0; m_prev_wren = 1'b0; m_prev_lu = 1'b0;
    m_prev_addr = '0; m_last_addr = '0; m_last_data = '0;
    m_wb_g = 1'b0; m_lu_g = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle();
    bus.i_wb_valid = 1'b0; bus.i_lu_valid = 1'b0; bus.i_iss_valid = 1'b0;
  endtask

  // One clock: check combinational outputs, predict and queue the write, then compare after the edge.
  task automatic step();
    logic        frc, m_wb_rdy, m_lu_rdy;
    logic [31:0] nb;
    wr_exp_t     e;
    #1;
    frc      = GUARD && (m_cnt == LIMIT);
    m_wb_rdy = !frc;
    m_lu_rdy = frc || !bus.i_wb_valid;
    chk("wb_ready", bus.o_wb_ready, m_wb_rdy);
    chk("lu_ready", bus.o_lu_ready, m_lu_rdy);
    chk("rs1_busy", bus.o_rs1_busy, m_busy[bus.i_rs1_addr]);
    chk("rs2_busy", bus.o_rs2_busy, m_busy[bus.i_rs2_addr]);
    chk("rd_busy",  bus.o_rd_busy,  m_busy[bus.i_iss_rd_addr]);
    m_wb_g = bus.i_wb_valid && !frc;
    m_lu_g = bus.i_lu_valid && !m_wb_g;
    nb = m_busy;
    if (m_prev_wren && m_prev_lu) nb[m_prev_addr] = 1'b0;
    if (bus.i_iss_valid && (bus.i_iss_rd_addr != 5'd0)) nb[bus.i_iss_rd_addr] = 1'b1;
    if (m_wb_g) begin
      e.wren = (bus.i_wb_rd_addr != 5'd0); e.addr = bus.i_wb_rd_addr; e.data = bus.i_wb_rd_data;
      m_prev_lu = 1'b0;
    end else if (m_lu_g) begin
      e.wren = (bus.i_lu_rd_addr != 5'd0); e.addr = bus.i_lu_rd_addr; e.data = bus.i_lu_rd_data;
      m_prev_lu = 1'b1;
    end else begin
      e.wren = 1'b0; e.addr = m_last_addr; e.data = m_last_data;
    end
    m_last_addr = e.addr; m_last_data = e.data;
    m_prev_wren = e.wren; m_prev_addr = e.addr;
    if (bus.i_lu_valid && m_lu_rdy) m_cnt = 0;
    else if (bus.i_lu_valid && (m_cnt < LIMIT)) m_cnt++;
    exp_q.push_back(e);
    @(posedge clk);
    m_busy = nb;
    #1;
    chk("exp_q_depth", exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("rd_wren", bus.o_rd_wren, e.wren);
      chk("rd_addr", bus.o_rd_addr, e.addr);
      chk("rd_data", bus.o_rd_data, e.data);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    model_clear();
    chk("rst_rd_wren", bus.o_rd_wren, 0);
    chk("rst_rd_addr", bus.o_rd_addr, 0);
    chk("rst_rd_data", bus.o_rd_data, 0);
    for (int r = 0; r < 32; r++) begin
      bus.i_rs1_addr = 5'(r);
      #0;
      chk("rst_busy", bus.o_rs1_busy, 0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n_pipe;
    logic        lu_seen, lu_done;
    logic [31:0] lu_d;
    rst = 1'b1;
    idle();
    bus.i_wb_rd_addr = '0; bus.i_wb_rd_data = '0;
    bus.i_lu_rd_addr = '0; bus.i_lu_rd_data = '0;
    bus.i_iss_rd_addr = '0; bus.i_rs1_addr = '0; bus.i_rs2_addr = '0;
    model_clear();
    do_reset();

    // Pipeline write x5
    bus.i_wb_valid = 1'b1; bus.i_wb_rd_addr = 5'd5; bus.i_wb_rd_data = 32'h1234_5678;
    step();
    chk("x5_wren", bus.o_rd_wren, 1);
    chk("x5_addr", bus.o_rd_addr, 5);
    chk("x5_data", bus.o_rd_data, 32'h1234_5678);
    idle();
    step();
    chk("idle_hold_data", bus.o_rd_data, 32'h1234_5678);

    // Long op to x7, decode reads rs1=7
    bus.i_iss_valid = 1'b1; bus.i_iss_rd_addr = 5'd7; bus.i_rs1_addr = 5'd7;
    step();
    bus.i_iss_valid = 1'b0;
    step(); step();
    chk("x7_busy_inflight", bus.o_rs1_busy, 1);
    bus.i_lu_valid = 1'b1; bus.i_lu_rd_addr = 5'd7; bus.i_lu_rd_data = 32'hCAFE_0007;
    step();
    bus.i_lu_valid = 1'b0;
    chk("x7_busy_during_wren", bus.o_rs1_busy, 1);
    step();
    chk("x7_busy_cleared", bus.o_rs1_busy, 0);

    // Re-issue x8 on the edge that retires it: set wins
    bus.i_iss_valid = 1'b1; bus.i_iss_rd_addr = 5'd8; bus.i_rs2_addr = 5'd8;
    step();
    bus.i_iss_valid = 1'b0;
    bus.i_lu_valid = 1'b1; bus.i_lu_rd_addr = 5'd8; bus.i_lu_rd_data = 32'h0000_0808;
    step();
    bus.i_lu_valid = 1'b0; bus.i_iss_valid = 1'b1;
    step();
    bus.i_iss_valid = 1'b0;
    step();
    chk("x8_set_wins", bus.o_rs2_busy, 1);
    bus.i_lu_valid = 1'b1; bus.i_lu_rd_data = 32'h0000_0809;
    step();
    bus.i_lu_valid = 1'b0;
    step();
    chk("x8_cleared", bus.o_rs2_busy, 0);

    // x0 from both sources, issue to x0
    bus.i_wb_valid = 1'b1; bus.i_wb_rd_addr = 5'd0; bus.i_wb_rd_data = 32'hDEAD_0000;
    step();
    chk("x0_wb_wren", bus.o_rd_wren, 0);
    bus.i_wb_valid = 1'b0;
    bus.i_lu_valid = 1'b1; bus.i_lu_rd_addr = 5'd0; bus.i_lu_rd_data = 32'hBEEF_0000;
    step();
    chk("x0_lu_wren", bus.o_rd_wren, 0);
    bus.i_lu_valid = 1'b0;
    bus.i_iss_valid = 1'b1; bus.i_iss_rd_addr = 5'd0;
    step();
    bus.i_iss_valid = 1'b0;
    step();
    chk("x0_rd_busy", bus.o_rd_busy, 0);

    // Contention: pipeline x3 vs long unit x9
    n_pipe = 0; lu_seen = 1'b0; lu_d = 32'h9000_0000;
    bus.i_lu_valid = 1'b1; bus.i_lu_rd_addr = 5'd9; bus.i_lu_rd_data = lu_d;
    bus.i_wb_valid = 1'b1; bus.i_wb_rd_addr = 5'd3;
    for (int i = 0; i < 8; i++) begin
      bus.i_wb_rd_data = 32'h0000_3000 + 32'(i);
      step();
      if (m_lu_g) begin
        if (!lu_seen) chk("lu_grant_addr", bus.o_rd_addr, 9);
        lu_seen = 1'b1;
        lu_d = lu_d + 1; bus.i_lu_rd_data = lu_d;
      end else if (!lu_seen) begin
        n_pipe++;
      end
    end
    chk("pipe_writes_before_lu", n_pipe, GUARD ? LIMIT : 8);
    bus.i_wb_valid = 1'b0;
    lu_done = 1'b0;
    for (int k = 0; k < 8 && !lu_done; k++) begin
      step();
      if (m_lu_g) lu_done = 1'b1;
    end
    chk("lu_drain", lu_done, 1);
    chk("lu_drain_addr", bus.o_rd_addr, 9);
    idle();
    step();

    // Randomised traffic honouring both handshakes
    for (int i = 0; i < 300; i++) begin
      if (!bus.i_wb_valid || m_wb_g) begin
        bus.i_wb_valid = 1'($urandom_range(0, 1));
        bus.i_wb_rd_addr = 5'($urandom_range(0, 7));
        bus.i_wb_rd_data = $urandom;
      end
      if (!bus.i_lu_valid || m_lu_g) begin
        bus.i_lu_valid = ($urandom_range(0, 2) == 0);
        bus.i_lu_rd_addr = 5'($urandom_range(0, 7));
        bus.i_lu_rd_data = $urandom;
      end
      bus.i_iss_valid = ($urandom_range(0, 3) == 0);
      bus.i_iss_rd_addr = 5'($urandom_range(0, 7));
      bus.i_rs1_addr = 5'($urandom_range(0, 7));
      bus.i_rs2_addr = 5'($urandom_range(0, 7));
      step();
    end

    // Reset mid-operation with requests pending
    idle();
    bus.i_iss_valid = 1'b1; bus.i_iss_rd_addr = 5'd4;
    step();
    bus.i_iss_rd_addr = 5'd6;
    step();
    bus.i_iss_valid = 1'b0;
    bus.i_wb_valid = 1'b1; bus.i_wb_rd_addr = 5'd10; bus.i_wb_rd_data = 32'hAAAA_5555;
    bus.i_lu_valid = 1'b1; bus.i_lu_rd_addr = 5'd11; bus.i_lu_rd_data = 32'h5555_AAAA;
    do_reset();
    idle();
    bus.i_rs1_addr = 5'd4; bus.i_rs2_addr = 5'd6;
    step();
    chk("post_rst_rs1", bus.o_rs1_busy, 0);
    chk("post_rst_wren", bus.o_rd_wren, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/rf_wb_ctrl.md
# rf_wb_ctrl

Write-port controller and scoreboard for the 32x32 integer register file. Arbitrates the single register-file write port between the in-order pipeline writeback and a long-latency unit (load/mul-div). Tracks destination registers of in-flight long-latency ops so issue logic can stall on RAW/WAW hazards. Sits between the writeback stage, the long-latency unit and the register file's `i_rd_*` inputs.

## Interface
- `STARVE_LIMIT`, 4: consecutive refused long-unit cycles before the pipeline is forced to yield (1..15).
- `i_clk`  in  1  clock, rising edge.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_wb_valid`  in  1  pipeline writeback request.
- `i_wb_rd_addr`  in  5  pipeline destination.
- `i_wb_rd_data`  in  32  pipeline result.
- `o_wb_ready`  out  1  pipeline write accepted this cycle.
- `i_lu_valid`  in  1  long-unit writeback request.
- `i_lu_rd_addr`  in  5  long-unit destination.
- `i_lu_rd_data`  in  32  long-unit result.
- `o_lu_ready`  out  1  long-unit write accepted this cycle.
- `i_iss_valid`  in  1  long-latency op issuing this cycle.
- `i_iss_rd_addr`  in  5  its destination.
- `i_rs1_addr`, `i_rs2_addr`  in  5  sources of the instruction in decode.
- `o_rs1_busy`, `o_rs2_busy`, `o_rd_busy`  out  1  scoreboard hit for rs1, rs2, `i_iss_rd_addr`.
- `o_rd_addr`  out  5, `o_rd_data`  out  32, `o_rd_wren`  out  1: registered write port to the register file.

## Operation
- Grant (combinational): the pipeline wins when `i_wb_valid`, unless force is set. The long unit wins when `i_lu_valid` and the pipeline does not win.
- `o_wb_ready` = !force. `o_lu_ready` = force | !i_wb_valid.
- A granted request is captured into `o_rd_*` at the next edge. `o_rd_wren`=1 only if the captured address is non-zero; writes to x0 are dropped but still accepted.
- Long-unit handshake: valid/addr/data must stay stable until `o_lu_ready`. The transfer occurs on an edge with valid&ready.
- Pipeline handshake: when `o_wb_ready`=0, the pipeline holds its writeback stage.
- Scoreboard: 32 busy bits, bit 0 hard-wired 0.
  - Set on an edge with `i_iss_valid` and a non-zero `i_iss_rd_addr`.
  - Cleared on an edge where `o_rd_wren`=1 and the registered source tag is the long unit. This is the same edge on which the register file stores the data.
  - Set and clear of the same bit on the same edge: set wins.
- Busy outputs are combinational reads of the scoreboard bits.
- Starvation counter (see Configuration):
  - Increments each cycle with `i_lu_valid` & !`o_lu_ready`, saturating at `STARVE_LIMIT`; resets to 0 on a long-unit transfer.
  - force = (count == `STARVE_LIMIT`).

## Timing
- Reset: `o_rd_wren`=0, `o_rd_addr`=0, `o_rd_data`=0, all busy bits 0, counter 0, source tag = pipeline.
- Reset mid-operation discards the pending registered write and all scoreboard state.
- Write latency: one cycle from accept to `o_rd_wren`. The register file stores at the following edge.
- A busy bit drops in the cycle after `o_rd_wren` high. From that cycle, decode reads the new value with no bypass.
- Ready outputs are combinational from valids and the counter: no registered stall cycle.
- No request in a cycle: `o_rd_wren`=0 next cycle; `o_rd_addr`/`o_rd_data` hold.

## Configuration
- `RF_WB_STARVE_GUARD_EN` defined: the starvation counter and forced yield exist as described.
- Not defined: no counter, force = 0, `o_wb_ready` tied 1, fixed pipeline priority. `STARVE_LIMIT` is unused.

## Structure
- Package `rf_ctrl_pkg`:
  - `XLEN`=32, `REG_ADDR_W`=5, `NUM_REGS`=32.
  - enum `wb_src_e` {WB_SRC_PIPE, WB_SRC_LU}.
  - `STARVE_CNT_W`=4.
- Sub-module `rf_scoreboard`: busy-bit array, set/clear ports, three combinational lookup ports.
- Top level holds the grant logic, starvation counter and output registers.

## Test plan
- Reset, then pipeline write x5=0x1234_5678 → next cycle `o_rd_wren`=1, `o_rd_addr`=5, `o_rd_data`=0x1234_5678; `o_wb_ready` stays 1.
- Issue long op to x7; decode rs1=7 → `o_rs1_busy`=1 until the cycle after the long-unit write of x7 appears on `o_rd_*`, then 0.
- Simultaneous pipeline (x3) and long-unit (x9) valid, guard compiled out → pipeline granted every cycle; `o_lu_ready`=0 until `i_wb_valid` drops.
- Guard enabled, `STARVE_LIMIT`=4, both valid continuously → 4 pipeline writes, then `o_wb_ready`=0 for one cycle with the long-unit write (x9) granted, then pipeline resumes.
- Write to x0 from either source → accepted (ready=1), `o_rd_wren`=0. Issue to x0 → `o_rd_busy` stays 0.
- Issue x7 on the same edge as the long-unit write of x7 clears it → bit remains busy. Assert `i_reset` mid-sequence → all busy 0, `o_rd_wren`=0 next cycle.
